// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: issues PC reads to instruction memory and buffers returned words for decode.
// Optional define FETCH_ALIGN_CHK_EN rejects misaligned PCs and pulses err_misalign.
module inst_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic        pc_valid,
  output logic        pc_ready,
  output logic [31:0] imem_addr,
  output logic        imem_rd,
  input  logic [31:0] imem_data,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        flush
`ifdef FETCH_ALIGN_CHK_EN
  ,output logic       err_misalign
`endif
);

  localparam logic [1:0] S_EMPTY   = 2'd0;
  localparam logic [1:0] S_PARTIAL = 2'd1;
  localparam logic [1:0] S_FULL    = 2'd2;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  logic [31:0]      data_mem [DEPTH];
  logic [31:0]      pc_mem   [DEPTH];
  logic [PTR_W-1:0] rptr, wptr;
  logic [PTR_W:0]   count, count_nxt, inflight;
  logic [1:0]       state, state_nxt;
  logic             rst_q, cap_valid;
  logic [31:0]      pend_pc, cap_pc, fetch_addr;
  logic             accept, issue, push, pop;

  // A read occupies a slot from issue until its word lands, so both pipeline
  // stages count against free space; otherwise back-to-back fetches overrun the FIFO.
  assign inflight = (PTR_W+1)'(imem_rd) + (PTR_W+1)'(cap_valid);
  assign pc_ready = !flush && !rst_q && ((count + inflight) < DEPTH_C);
  assign accept   = pc_valid && pc_ready;
  assign push     = cap_valid;
  assign pop      = instr_valid && instr_ready;

`ifdef FETCH_ALIGN_CHK_EN
  logic misalign;
  assign misalign   = (pc_in[1:0] != 2'b00);
  assign issue      = accept && !misalign;
  assign fetch_addr = pc_in;
`else
  assign issue      = accept;
  assign fetch_addr = {pc_in[31:2], 2'b00};
`endif

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
    state_nxt = S_PARTIAL;
    if (count_nxt == '0)          state_nxt = S_EMPTY;
    else if (count_nxt == DEPTH_C) state_nxt = S_FULL;
  end

  assign instr_valid = (state != S_EMPTY);
  assign instr_out   = instr_valid ? data_mem[rptr] : 32'h0;
  assign instr_pc    = instr_valid ? pc_mem[rptr]   : 32'h0;

  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      imem_rd   <= 1'b0;
      imem_addr <= 32'h0;
      pend_pc   <= 32'h0;
      cap_valid <= 1'b0;
      cap_pc    <= 32'h0;
      count     <= '0;
      rptr      <= '0;
      wptr      <= '0;
      state     <= S_EMPTY;
`ifdef FETCH_ALIGN_CHK_EN
      err_misalign <= 1'b0;
`endif
    end else if (flush) begin
      // Clearing cap_valid drops the word still on its way back from memory.
      imem_rd   <= 1'b0;
      cap_valid <= 1'b0;
      count     <= '0;
      rptr      <= '0;
      wptr      <= '0;
      state     <= S_EMPTY;
`ifdef FETCH_ALIGN_CHK_EN
      err_misalign <= 1'b0;
`endif
    end else begin
      imem_rd <= issue;
      if (issue) begin
        imem_addr <= fetch_addr;
        pend_pc   <= pc_in;
      end
      cap_valid <= imem_rd;
      cap_pc    <= pend_pc;
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count_nxt;
      state <= state_nxt;
`ifdef FETCH_ALIGN_CHK_EN
      err_misalign <= accept && misalign;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && push) begin
      data_mem[wptr] <= imem_data;
      pc_mem[wptr]   <= cap_pc;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed self-checking bench for inst_fetch_queue; memory returns 0xA0 + (addr >> 2).
// Covers the FETCH_ALIGN_CHK_EN build when that define is set.
module tb_inst_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        pc_valid;
  logic        pc_ready;
  logic [31:0] imem_addr;
  logic        imem_rd;
  logic [31:0] imem_data = 32'h0;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        flush;
`ifdef FETCH_ALIGN_CHK_EN
  logic        err_misalign;
`endif

  int checks   = 0;
  int failures = 0;
  int acc, sent, got;

  inst_fetch_queue #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_data(imem_data),
    .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .flush(flush)
`ifdef FETCH_ALIGN_CHK_EN
    , .err_misalign(err_misalign)
`endif
  );

  always #5 clk = ~clk;

  // Instruction memory: one-cycle read latency.
  always @(posedge clk) imem_data <= imem_rd ? (32'hA0 + (imem_addr >> 2)) : 32'h0;

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic pv, input logic [31:0] pc, input logic ir, input logic fl);
    pc_valid    = pv;
    pc_in       = pc;
    instr_ready = ir;
    flush       = fl;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic        st_valid [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic        st_rd    [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [31:0] st_out   [7] = '{32'h0, 32'h0, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'h0};
  logic [31:0] st_pc    [7] = '{32'h0, 32'h0, 32'h0, 32'h4, 32'h8, 32'hC, 32'h0};

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    nxt();
    nxt();
    checkOutput("rst_valid", instr_valid, 1'b0);
    checkOutput("rst_ready", pc_ready, 1'b0);
    checkOutput("rst_rd", imem_rd, 1'b0);
    checkOutput("rst_addr", imem_addr, 32'h0);
    checkOutput("rst_out", instr_out, 32'h0);
    checkOutput("rst_pc", instr_pc, 32'h0);
    rst = 1'b0;
    #1;
    checkOutput("ready_rst_q", pc_ready, 1'b0);
    nxt();
    #1;
    checkOutput("ready_after_rst", pc_ready, 1'b1);

    // Stream of four aligned fetches, decode always ready.
    applyStimulus(1'b1, 32'h0, 1'b1, 1'b0);
    for (int k = 0; k < 7; k++) begin
      nxt();
      applyStimulus(k < 3, 32'(4 * (k + 1)), 1'b1, 1'b0);
      #1;
      checkOutput("stream_valid", instr_valid, st_valid[k]);
      checkOutput("stream_out", instr_out, st_out[k]);
      checkOutput("stream_pc", instr_pc, st_pc[k]);
      checkOutput("stream_rd", imem_rd, st_rd[k]);
    end
    checkOutput("stream_addr", imem_addr, 32'hC);

    // Back-pressure: decode stalled, six offers.
    acc = 0;
    for (int j = 0; j < 6; j++) begin
      applyStimulus(1'b1, 32'h10 + 32'(acc) * 4, 1'b0, 1'b0);
      #1;
      if (pc_ready) acc++;
      nxt();
    end
    checkOutput("bp_accepted", 32'(acc), 32'd4);
    applyStimulus(1'b1, 32'h20, 1'b1, 1'b0);
    #1;
    checkOutput("bp_full_ready", pc_ready, 1'b0);
    checkOutput("bp_head_out", instr_out, 32'hA4);
    checkOutput("bp_head_pc", instr_pc, 32'h10);
    nxt();
    applyStimulus(1'b1, 32'h20, 1'b0, 1'b0);
    #1;
    checkOutput("bp_ready_after_pop", pc_ready, 1'b1);
    checkOutput("bp_head2_pc", instr_pc, 32'h14);
    nxt();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    #1;
    checkOutput("bp_fifth_rd", imem_rd, 1'b1);
    checkOutput("bp_fifth_addr", imem_addr, 32'h20);
    checkOutput("bp_refull_ready", pc_ready, 1'b0);
    nxt();
    checkOutput("drain_pc1", instr_pc, 32'h18);
    nxt();
    checkOutput("drain_pc2", instr_pc, 32'h1C);
    nxt();
    checkOutput("drain_pc3", instr_pc, 32'h20);
    checkOutput("drain_out3", instr_out, 32'hA8);
    nxt();
    checkOutput("drain_empty", instr_valid, 1'b0);

    // Build count=2, then a push and pop on the same edge.
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b0);
    nxt();
    applyStimulus(1'b1, 32'h104, 1'b0, 1'b0);
    nxt();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    nxt();
    nxt();
    applyStimulus(1'b1, 32'h108, 1'b0, 1'b0);
    #1;
    checkOutput("pp_head0", instr_pc, 32'h100);
    nxt();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    nxt();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    #1;
    checkOutput("pp_before_out", instr_out, 32'hE0);
    nxt();
    checkOutput("pp_head1", instr_pc, 32'h104);
    checkOutput("pp_out1", instr_out, 32'hE1);
    nxt();
    checkOutput("pp_head2", instr_pc, 32'h108);
    nxt();
    checkOutput("pp_count_two", instr_valid, 1'b0);

    // Eight consecutive fetches wrapping the pointers.
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      applyStimulus(sent < 8, 32'h10C + 32'(sent) * 4, 1'b1, 1'b0);
      #1;
      if (instr_valid) begin
        checkOutput("wrap_pc", instr_pc, 32'h10C + 32'(got) * 4);
        checkOutput("wrap_out", instr_out, 32'hA0 + ((32'h10C + 32'(got) * 4) >> 2));
        got++;
      end
      if (pc_valid && pc_ready) sent++;
      nxt();
    end
    checkOutput("wrap_count", 32'(got), 32'd8);

    // Flush with two queued and one word returning.
    applyStimulus(1'b1, 32'h200, 1'b0, 1'b0);
    nxt();
    applyStimulus(1'b1, 32'h204, 1'b0, 1'b0);
    nxt();
    applyStimulus(1'b1, 32'h208, 1'b0, 1'b0);
    nxt();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    nxt();
    applyStimulus(1'b1, 32'h300, 1'b1, 1'b1);
    #1;
    checkOutput("fl_ready", pc_ready, 1'b0);
    checkOutput("fl_pre_valid", instr_valid, 1'b1);
    nxt();
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b0);
    #1;
    checkOutput("fl_valid", instr_valid, 1'b0);
    checkOutput("fl_out", instr_out, 32'h0);
    checkOutput("fl_no_rd", imem_rd, 1'b0);
    nxt();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    checkOutput("fl_rd40", imem_rd, 1'b1);
    checkOutput("fl_addr40", imem_addr, 32'h40);
    checkOutput("fl_dropped", instr_valid, 1'b0);
    nxt();
    checkOutput("fl_still_empty", instr_valid, 1'b0);
    nxt();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    #1;
    checkOutput("fl_sole_pc", instr_pc, 32'h40);
    checkOutput("fl_sole_out", instr_out, 32'hB0);
    nxt();
    checkOutput("fl_sole_only", instr_valid, 1'b0);

    // Reset with three entries queued.
    applyStimulus(1'b1, 32'h300, 1'b0, 1'b0);
    nxt();
    applyStimulus(1'b1, 32'h304, 1'b0, 1'b0);
    nxt();
    applyStimulus(1'b1, 32'h308, 1'b0, 1'b0);
    nxt();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    nxt();
    nxt();
    applyStimulus(1'b1, 32'h30C, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("mr_pre_out", instr_out, 32'h160);
    nxt();
    rst = 1'b0;
    #1;
    checkOutput("mr_valid", instr_valid, 1'b0);
    checkOutput("mr_ready", pc_ready, 1'b0);
    checkOutput("mr_rd", imem_rd, 1'b0);
    checkOutput("mr_out", instr_out, 32'h0);
    nxt();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    checkOutput("mr_ready_back", pc_ready, 1'b1);
    checkOutput("mr_rd_after", imem_rd, 1'b0);
    nxt();

    // Misaligned PC 0x06.
    applyStimulus(1'b1, 32'h6, 1'b1, 1'b0);
    #1;
    checkOutput("mis_ready", pc_ready, 1'b1);
    nxt();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    #1;
`ifdef FETCH_ALIGN_CHK_EN
    checkOutput("mis_err", err_misalign, 1'b1);
    checkOutput("mis_no_rd", imem_rd, 1'b0);
    nxt();
    checkOutput("mis_err_pulse", err_misalign, 1'b0);
    nxt();
    checkOutput("mis_fifo_empty", instr_valid, 1'b0);
`else
    checkOutput("mis_rd", imem_rd, 1'b1);
    checkOutput("mis_addr", imem_addr, 32'h4);
    nxt();
    nxt();
    checkOutput("mis_valid", instr_valid, 1'b1);
    checkOutput("mis_pc", instr_pc, 32'h6);
    checkOutput("mis_out", instr_out, 32'hA1);
`endif
    nxt();
    checkOutput("mis_end_empty", instr_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Consumer end of the PC address stream: accepts 32-bit fetch addresses from the program counter and issues reads to instruction memory.
- Captures the returned instruction words into a DEPTH-entry FIFO, each tagged with its PC.
- Hands the words to the decode stage over a valid/ready handshake.
- Back-pressures the PC via pc_ready, and is flushable on a branch or redirect.

Parameters:
- DEPTH, 4, number of instruction FIFO entries (power of 2, 2..16)
- PTR_W, 2, log2(DEPTH)

Ports:
- clk  input  1  clock; all state updates on posedge
- rst  input  1  synchronous, active-high reset
- pc_in  input  32  fetch address from the program counter
- pc_valid  input  1  pc_in holds a valid address
- pc_ready  output  1  block accepts pc_in this cycle
- imem_addr  output  32  instruction memory read address
- imem_rd  output  1  read strobe, one cycle per read
- imem_data  input  32  read data, valid exactly 1 cycle after imem_rd
- instr_out  output  32  instruction at the FIFO head
- instr_pc  output  32  PC of the instruction at the FIFO head
- instr_valid  output  1  FIFO head valid
- instr_ready  input  1  decode stage consumes the head this cycle
- flush  input  1  discard all queued and in-flight fetches

Behaviour:
- Reset (rst=1 at posedge) forces every output to 0 and clears count, in-flight flag, and read/write pointers. Reset overrides flush and all handshakes, including mid-operation.
- Accept rule: accept = pc_valid & pc_ready.
  - pc_ready = !flush & !rst_q & ((count + inflight) < DEPTH).
  - rst_q is the registered rst, so pc_ready is low in the first cycle after reset.
- On accept:
  - imem_rd=1 and imem_addr=pc_in are registered, so both appear the cycle after accept.
  - inflight is set and pc_in is saved in pend_pc.
- One cycle after imem_rd, imem_data and pend_pc are written to the FIFO tail, wptr advances, and inflight clears unless a new read was issued. Back-to-back accepts sustain one fetch per cycle.
- Total latency from accept to instr_valid is 3 clocks: rd issue, data capture, head visible.
- Pop: when instr_valid & instr_ready, rptr advances at the next posedge.
- Simultaneous push and pop: count is unchanged, and pointers wrap modulo DEPTH.
- Full: count + inflight == DEPTH forces pc_ready=0. Empty: count==0 forces instr_valid=0, and instr_out/instr_pc drive 0.
- FIFO state machine (count-based):
  - EMPTY → PARTIAL on push.
  - PARTIAL → FULL when count reaches DEPTH.
  - FULL → PARTIAL on pop.
  - PARTIAL → EMPTY when the last entry pops with no push.
  - Any state → EMPTY on flush.
- Flush (registered, takes effect at posedge):
  - count, rptr and wptr are cleared and inflight is cleared.
  - Read data returning in the cycle after flush is dropped.
  - pc_ready=0 during the flush cycle; a pop in the same cycle is ignored.
- Address arithmetic is 32-bit unsigned. The block never modifies the address beyond the alignment handling below.

Optional Feature:
- Macro FETCH_ALIGN_CHK_EN.
- Defined:
  - Adds output port err_misalign (1 bit).
  - An accepted pc_in with its two least-significant bits nonzero is not sent to memory: imem_rd stays 0 and err_misalign pulses high for exactly 1 cycle (the cycle after accept).
  - The address is dropped and the FIFO is untouched. err_misalign resets to 0.
- Not defined:
  - No err_misalign port.
  - imem_addr carries pc_in with its two least-significant bits forced to 0, and the fetch proceeds normally.

Test Plan:
- Reset mid-stream: 3 entries queued, assert rst for 1 cycle → instr_valid=0, pc_ready=0 next cycle, pc_ready=1 the cycle after, and imem_rd=0.
- Stream: pc_in 0x00,0x04,0x08,0x0C on consecutive cycles with instr_ready=1, imem returning 0xA0..0xA3 → instr_out 0xA0..0xA3 with instr_pc 0x00..0x0C, first instr_valid 3 clocks after the first accept, one per cycle.
- Back-pressure: instr_ready=0 and 6 addresses offered → exactly 4 accepted, pc_ready=0 after the 4th; one pop → pc_ready=1 next cycle, 5th address accepted.
- Simultaneous push/pop at count=2 → count stays 2 and order is preserved across pointer wrap (8 consecutive fetches, DEPTH=4).
- Flush with 2 queued and 1 in flight → instr_valid=0 next cycle, the in-flight word is never presented, and the next address 0x40 delivers its word as the sole entry.
- With FETCH_ALIGN_CHK_EN: pc_in=0x06 → err_misalign=1 for 1 cycle, no imem_rd, FIFO count unchanged. Without the macro: pc_in=0x06 → imem_addr=0x04.
